// File: rtl/add_rr_arbiter_if.sv
// Handshake bundle between requesters, shared adder and consumer.
// Arbiter takes the slave view; the requester side takes master.
interface add_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic [WIDTH:0]           add_sum;
  logic                     rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH:0]           rsp_sum;
  logic                     rsp_ready;

  modport master (
    output req_valid, req_a, req_b,
    output add_sum, rsp_ready,
    input  req_ready, add_a, add_b,
    input  rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  add_sum, rsp_ready,
    output req_ready, add_a, add_b,
    output rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/add_rr_arbiter.sv
// Round-robin arbiter sharing one registered adder.
// One op in flight: IDLE -> ISSUE -> WAIT -> RESP.
module add_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ADD_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  add_rr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  CNT0 = CW'(ADD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [IDW-1:0]     w_gnt;
  logic [IDW-1:0]     w_idx;
  logic               w_any;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic               r_rsp_valid;
  logic [WIDTH:0]     r_rsp_sum;
  logic [NUM_REQ-1:0] w_ready;

  // first valid requester at or after r_ptr, wrapping
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  // next state and the ISSUE-only accept pulse
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_ready[r_id] = 1'b1;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // operand capture, latency count, response and pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_add_a <= bus.req_a[int'(w_gnt)*WIDTH +: WIDTH];
            r_add_b <= bus.req_b[int'(w_gnt)*WIDTH +: WIDTH];
            r_id    <= w_gnt;
          end
        end
        S_ISSUE: begin
          r_cnt <= CNT0;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_sum   <= bus.add_sum;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_id == LAST) ? '0 : r_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_sum   = r_rsp_sum;

endmodule

// File: tb/tb_add_rr_arbiter.sv
// Bench for add_rr_arbiter: vector table, corner sequences,
// and random traffic against a transaction-level model.
module tb_add_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int ADD_LAT = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  add_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  add_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH),
    .ADD_LAT(ADD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // shared adder: registered sum, ADD_LAT stages deep
  logic [WIDTH:0] pipe [ADD_LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ADD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
      for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.add_sum = pipe[ADD_LAT-1];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // one op from IDLE with rsp_ready high; grant seen after first edge
  task automatic run_op(input logic [3:0] v, input logic [15:0] a,
                        input logic [15:0] b, input int eid,
                        input int esum, input string nm);
    int n;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.req_ready == '0 && n < 10);
    chk({nm, "_ready"}, 32'(bus.req_ready), 32'(1) << eid);
    bus.req_valid = '0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.rsp_valid && n < 20);
    chk({nm, "_lat"}, n, 1 + ADD_LAT);
    chk({nm, "_id"}, 32'(bus.rsp_id), eid);
    chk({nm, "_sum"}, 32'(bus.rsp_sum), esum);
    cyc();
    chk({nm, "_done"}, 32'(bus.rsp_valid), 0);
  endtask

  // winner = valid index with smallest rotational distance from p
  function automatic int pick(input logic [3:0] v, input int p);
    int best = -1;
    int bd   = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i] && ((i - p + NUM_REQ) % NUM_REQ) < bd) begin
        bd   = (i - p + NUM_REQ) % NUM_REQ;
        best = i;
      end
    end
    return best;
  endfunction

  typedef struct {
    logic [3:0]  v;
    logic [15:0] a;
    logic [15:0] b;
    int          id;
    int          sum;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int ids[$];
    int sums[$];
    int exp_ids  [5];
    int exp_sums [5];
    int last_g;
    int last_id;
    int gid;
    int n;
    int m_ptr, m_id, m_age, m_sum, m_rsum;
    bit m_busy, m_rsp;
    logic [3:0]  m_a, m_b, rv, e_rdy;
    logic [15:0] ra, rb;
    logic        rr;
    logic [19:0] e_vec, a_vec;

    tbl[0] = '{4'b0001, 16'h0004, 16'h0004, 0, 8};
    tbl[1] = '{4'b1111, 16'hFFFF, 16'hFFFF, 1, 30};
    tbl[2] = '{4'b0011, 16'h0003, 16'h0009, 0, 12};
    tbl[3] = '{4'b0100, 16'h0700, 16'h0800, 2, 15};
    tbl[4] = '{4'b1001, 16'hF002, 16'h1002, 3, 16};
    tbl[5] = '{4'b1001, 16'hF002, 16'h1002, 0, 4};
    tbl[6] = '{4'b0110, 16'h0190, 16'h0060, 1, 15};
    exp_ids  = '{0, 1, 2, 3, 0};
    exp_sums = '{1, 2, 3, 4, 1};

    // reset values
    do_reset();
    chk("reset", {bus.req_ready, bus.add_a, bus.add_b, bus.rsp_valid,
                  bus.rsp_id, bus.rsp_sum}, 0);

    // vector table: single ops, max operands, wrap-around
    for (int i = 0; i < 7; i++)
      run_op(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].id, tbl[i].sum,
             $sformatf("tbl%0d", i));

    // all requesters held valid, back-to-back
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_a     = 16'h3210;
    bus.req_b     = 16'h1111;
    bus.rsp_ready = 1'b1;
    last_g  = -1;
    last_id = -1;
    for (int t = 0; t < 80 && ids.size() < 5; t++) begin
      cyc();
      if (bus.req_ready != '0) begin
        gid = $clog2(bus.req_ready);
        if (last_g >= 0) begin
          chk("b2b_gap", t - last_g, 3 + ADD_LAT);
          chk("b2b_norepeat", 32'(gid != last_id), 1);
        end
        last_g  = t;
        last_id = gid;
      end
      if (bus.rsp_valid) begin
        ids.push_back(int'(bus.rsp_id));
        sums.push_back(int'(bus.rsp_sum));
      end
    end
    chk("b2b_count", ids.size(), 5);
    for (int i = 0; i < ids.size() && i < 5; i++) begin
      chk($sformatf("b2b_id%0d", i), ids[i], exp_ids[i]);
      chk($sformatf("b2b_sum%0d", i), sums[i], exp_sums[i]);
    end

    // backpressure: response held, no new grant
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_a     = 16'h0050;
    bus.req_b     = 16'h0060;
    bus.rsp_ready = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.req_ready == '0 && n < 10);
    chk("bp_grant", 32'(bus.req_ready), 32'h2);
    bus.req_valid = 4'b1111;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.rsp_valid && n < 20);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i),
          {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.req_ready},
          {1'b1, 2'd1, 5'd11, 4'b0000});
      cyc();
    end
    bus.rsp_ready = 1'b1;
    cyc();
    chk("bp_release", 32'(bus.rsp_valid), 0);
    cyc();
    chk("bp_next_grant", 32'(bus.req_ready), 32'h4);
    bus.req_valid = '0;

    // reset while an op waits on the adder
    do_reset();
    run_op(4'b0100, 16'h0300, 16'h0400, 2, 7, "pre_rst");
    bus.req_valid = 4'b0001;
    bus.req_a     = 16'h0001;
    bus.req_b     = 16'h0001;
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.req_ready == '0 && n < 10);
    chk("rst_grant", 32'(bus.req_ready), 32'h1);
    cyc();
    rst = 1'b1;
    bus.req_valid = '0;
    cyc();
    chk("rst_wait", {bus.req_ready, bus.add_a, bus.add_b, bus.rsp_valid,
                     bus.rsp_id, bus.rsp_sum}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("rst_norsp%0d", i), 32'(bus.rsp_valid), 0);
    end
    run_op(4'b1001, 16'hF002, 16'h1002, 0, 4, "post_rst");

    // random traffic against transaction model
    do_reset();
    m_ptr = 0; m_id = 0; m_age = 0; m_sum = 0; m_rsum = 0;
    m_busy = 0; m_rsp = 0; m_a = '0; m_b = '0;
    for (int c = 0; c < 400; c++) begin
      rv = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      bus.req_valid = rv;
      bus.req_a     = ra;
      bus.req_b     = rb;
      bus.rsp_ready = rr;
      if (!m_busy) begin
        if (rv != '0) begin
          m_id   = pick(rv, m_ptr);
          m_a    = ra[4*m_id +: 4];
          m_b    = rb[4*m_id +: 4];
          m_sum  = int'(m_a) + int'(m_b);
          m_busy = 1;
          m_age  = 0;
        end
      end else begin
        m_age++;
        if (m_rsp) begin
          if (rr) begin
            m_rsp  = 0;
            m_busy = 0;
            m_ptr  = (m_id + 1) % NUM_REQ;
          end
        end else if (m_age == 1 + ADD_LAT) begin
          m_rsp  = 1;
          m_rsum = m_sum;
        end
      end
      cyc();
      e_rdy = (m_busy && m_age == 0) ? 4'(1 << m_id) : 4'b0;
      e_vec = {e_rdy, m_a, m_b, m_rsp, 2'(m_id), 5'(m_rsum)};
      a_vec = {bus.req_ready, bus.add_a, bus.add_b, bus.rsp_valid,
               bus.rsp_id, bus.rsp_sum};
      chk($sformatf("rnd%0d", c), 32'(a_vec), 32'(e_vec));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
